// File: rtl/intr_ctrl_n_if.sv
// Bus between the CPU interrupt-register path and intr_ctrl_n: register
// write/read port, source lines and the request/ack/done handshake.
interface intr_ctrl_n_if #(
  parameter int N_SRC = 8,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [31:0]       wr_data;
  logic [2:0]        rd_addr;
  logic [31:0]       rd_data;
  logic [N_SRC-1:0]  irq_src;
  logic              irq_req;
  logic [ID_W-1:0]   irq_id;
  logic [31:0]       irq_vec;
  logic              irq_ack;
  logic              irq_done;
  logic              in_service;

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr, irq_src, irq_ack, irq_done,
    output rd_data, irq_req, irq_id, irq_vec, in_service
  );

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr, irq_src, irq_ack, irq_done,
    input  rd_data, irq_req, irq_id, irq_vec, in_service
  );
endinterface

// File: rtl/intr_ctrl_n.sv
// N-source interrupt controller: pending/mask/mode registers, fixed
// lowest-index priority, per-source vector and a non-nesting req/ack/done FSM.
module intr_ctrl_n #(
  parameter int N_SRC      = 8,
  parameter int VEC_STRIDE = 4,
  parameter int ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  intr_ctrl_n_if.slave bus
);

  localparam logic [2:0] A_EN     = 3'd1;
  localparam logic [2:0] A_VEC    = 3'd2;
  localparam logic [2:0] A_MASK   = 3'd3;
  localparam logic [2:0] A_PEND   = 3'd4;
  localparam logic [2:0] A_MODE   = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             en_q, en_d;
  logic [31:0]      vec_q, vec_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] src_q;

  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] set_v;
  logic [N_SRC-1:0] w1c_v;
  logic [N_SRC-1:0] ack_clr;
  logic             ack_take;
  logic [31:0]      rd_data;

  function automatic logic [ID_W-1:0] prio_enc(input logic [N_SRC-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  function automatic logic wr_hit(input logic en, input logic [2:0] addr,
                                  input logic [2:0] target);
    return en && (addr == target);
  endfunction

  assign eligible = {N_SRC{en_q}} & pend_q & mask_q;
  assign ack_take = (state_q == S_REQ) && bus.irq_ack;

  // Configuration register writes
  always_comb begin
    en_d   = en_q;
    vec_d  = vec_q;
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_hit(bus.wr_en, bus.wr_addr, A_EN))   en_d   = bus.wr_data[0];
    if (wr_hit(bus.wr_en, bus.wr_addr, A_VEC))  vec_d  = bus.wr_data;
    if (wr_hit(bus.wr_en, bus.wr_addr, A_MASK)) mask_d = bus.wr_data[N_SRC-1:0];
    if (wr_hit(bus.wr_en, bus.wr_addr, A_MODE)) mode_d = bus.wr_data[N_SRC-1:0];
  end

  // Pending: edge sources set on a rising sample, level sources set while high;
  // a set in the same cycle as any clear keeps the bit.
  always_comb begin
    set_v   = (mode_q & bus.irq_src & ~src_q) | (~mode_q & bus.irq_src);
    w1c_v   = wr_hit(bus.wr_en, bus.wr_addr, A_PEND) ? bus.wr_data[N_SRC-1:0] : '0;
    ack_clr = '0;
    if (ack_take && mode_q[id_q]) ack_clr[id_q] = 1'b1;
    pend_d  = set_v | (pend_q & ~w1c_v & ~ack_clr);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      S_IDLE: begin
        if (|eligible) begin
          state_d = S_REQ;
          id_d    = prio_enc(eligible);
        end
      end
      S_REQ: begin
        // An ack in the same cycle as a withdrawal still takes the interrupt.
        if (bus.irq_ack)           state_d = S_ACTIVE;
        else if (!eligible[id_q])  state_d = S_IDLE;
      end
      S_ACTIVE: begin
        if (bus.irq_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      en_q    <= 1'b0;
      vec_q   <= '0;
      mask_q  <= '0;
      mode_q  <= '1;
      pend_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      en_q    <= en_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      src_q   <= bus.irq_src;
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.rd_addr)
      A_EN:     rd_data[0]         = en_q;
      A_VEC:    rd_data            = vec_q;
      A_MASK:   rd_data[N_SRC-1:0] = mask_q;
      A_PEND:   rd_data[N_SRC-1:0] = pend_q;
      A_MODE:   rd_data[N_SRC-1:0] = mode_q;
      A_STATUS: begin
        rd_data[31]       = (state_q == S_ACTIVE);
        rd_data[ID_W-1:0] = id_q;
      end
      default:  rd_data = '0;
    endcase
  end

  assign bus.rd_data    = rd_data;
  assign bus.irq_req    = (state_q == S_REQ);
  assign bus.in_service = (state_q == S_ACTIVE);
  assign bus.irq_id     = id_q;
  assign bus.irq_vec    = vec_q + (32'(id_q) * 32'(VEC_STRIDE));

endmodule

// File: tb/tb_intr_ctrl_n.sv
// Scenario bench for intr_ctrl_n; expected requests are queued when a source
// is driven and popped when the controller raises irq_req.
module tb_intr_ctrl_n;
  localparam int N = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  intr_ctrl_n_if #(.N_SRC(N)) bus();
  intr_ctrl_n #(.N_SRC(N), .VEC_STRIDE(4)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] vec;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] vec_base = '0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.rd_addr = a; #1;
    d = bus.rd_data;
  endtask

  task automatic pulse(input logic [N-1:0] m);
    bus.irq_src = m;
    tick();
    bus.irq_src = '0;
  endtask

  task automatic expect_req(input int id);
    exp_t e;
    e.id  = id[2:0];
    e.vec = vec_base + 32'(id) * 32'd4;
    sb.push_back(e);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && bus.irq_req !== 1'b1; i++) tick();
  endtask

  task automatic ack();
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
  endtask

  task automatic done();
    bus.irq_done = 1'b1; tick(); bus.irq_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b want=0", bus.irq_req); end
    checks++; if (bus.in_service !== 1'b0) begin errors++; $display("FAIL rst_insvc got=%b want=0", bus.in_service); end
    checks++; if (bus.irq_id !== 3'd0) begin errors++; $display("FAIL rst_id got=%0d want=0", bus.irq_id); end
    checks++; if (bus.irq_vec !== 32'h0) begin errors++; $display("FAIL rst_vec got=%h want=0", bus.irq_vec); end
    rd(3'd0, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rst_rd0 got=%h want=0", r); end
    rd(3'd5, r);
    checks++; if (r !== 32'hFF) begin errors++; $display("FAIL rst_mode got=%h want=000000ff", r); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] r;
    exp_t e;
    wr(3'd1, 32'h1); wr(3'd3, 32'h1); wr(3'd2, 32'h100);
    vec_base = 32'h100;
    expect_req(0);
    pulse(8'h01);
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL basic_lat1 got=%b want=0", bus.irq_req); end
    tick();
    checks++; if (bus.irq_req !== 1'b1) begin errors++; $display("FAIL basic_lat2 got=%b want=1", bus.irq_req); end
    e = sb.pop_front();
    checks++; if (bus.irq_id !== e.id || bus.irq_vec !== e.vec) begin errors++; $display("FAIL basic_req id=%0d vec=%h want id=%0d vec=%h", bus.irq_id, bus.irq_vec, e.id, e.vec); end
    ack();
    checks++; if (bus.in_service !== 1'b1 || bus.irq_req !== 1'b0) begin errors++; $display("FAIL basic_ack insvc=%b req=%b want 1/0", bus.in_service, bus.irq_req); end
    rd(3'd4, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL basic_pend got=%h want=0", r); end
    rd(3'd6, r);
    checks++; if (r !== 32'h8000_0000) begin errors++; $display("FAIL basic_status got=%h want=80000000", r); end
    done();
    checks++; if (bus.in_service !== 1'b0) begin errors++; $display("FAIL basic_done got=%b want=0", bus.in_service); end
  endtask

  task automatic test_priority();
    exp_t e;
    wr(3'd3, 32'hFF); wr(3'd2, 32'h200);
    vec_base = 32'h200;
    expect_req(2); expect_req(5);
    pulse(8'h24);
    wait_req(5);
    checks++; if (bus.irq_req !== 1'b1) begin errors++; $display("FAIL prio_req1 got=%b want=1", bus.irq_req); end
    e = sb.pop_front();
    checks++; if (bus.irq_id !== e.id || bus.irq_vec !== e.vec) begin errors++; $display("FAIL prio_first id=%0d vec=%h want id=%0d vec=%h", bus.irq_id, bus.irq_vec, e.id, e.vec); end
    ack(); done();
    wait_req(5);
    checks++; if (bus.irq_req !== 1'b1) begin errors++; $display("FAIL prio_req2 got=%b want=1", bus.irq_req); end
    e = sb.pop_front();
    checks++; if (bus.irq_id !== e.id || bus.irq_vec !== e.vec) begin errors++; $display("FAIL prio_second id=%0d vec=%h want id=%0d vec=%h", bus.irq_id, bus.irq_vec, e.id, e.vec); end
    wr(3'd2, 32'h300);
    vec_base = 32'h300;
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== 3'd5 || bus.irq_vec !== 32'h314) begin errors++; $display("FAIL vec_live req=%b id=%0d vec=%h want 1/5/00000314", bus.irq_req, bus.irq_id, bus.irq_vec); end
    ack(); done();
  endtask

  task automatic test_no_nesting();
    logic [31:0] r;
    logic quiet;
    exp_t e;
    expect_req(3);
    pulse(8'h08);
    wait_req(5);
    e = sb.pop_front();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== e.id || bus.irq_vec !== e.vec) begin errors++; $display("FAIL nest_first req=%b id=%0d vec=%h want 1/%0d/%h", bus.irq_req, bus.irq_id, bus.irq_vec, e.id, e.vec); end
    ack();
    pulse(8'h01);
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.irq_req !== 1'b0) quiet = 1'b0;
      tick();
    end
    checks++; if (quiet !== 1'b1 || bus.in_service !== 1'b1) begin errors++; $display("FAIL nest_quiet quiet=%b insvc=%b want 1/1", quiet, bus.in_service); end
    rd(3'd4, r);
    checks++; if (r !== 32'h01) begin errors++; $display("FAIL nest_pend got=%h want=00000001", r); end
    expect_req(0);
    done();
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL nest_done_req got=%b want=0", bus.irq_req); end
    tick();
    checks++; if (bus.irq_req !== 1'b1) begin errors++; $display("FAIL nest_next_req got=%b want=1", bus.irq_req); end
    e = sb.pop_front();
    checks++; if (bus.irq_id !== e.id || bus.irq_vec !== e.vec) begin errors++; $display("FAIL nest_next id=%0d vec=%h want id=%0d vec=%h", bus.irq_id, bus.irq_vec, e.id, e.vec); end
    ack(); done();
  endtask

  task automatic test_withdraw();
    logic [31:0] r;
    exp_t e;
    expect_req(3);
    pulse(8'h08);
    wait_req(5);
    e = sb.pop_front();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== e.id || bus.irq_vec !== e.vec) begin errors++; $display("FAIL wd_req req=%b id=%0d vec=%h want 1/%0d/%h", bus.irq_req, bus.irq_id, bus.irq_vec, e.id, e.vec); end
    wr(3'd3, 32'h0);
    tick();
    checks++; if (bus.irq_req !== 1'b0 || bus.in_service !== 1'b0) begin errors++; $display("FAIL wd_idle req=%b insvc=%b want 0/0", bus.irq_req, bus.in_service); end
    rd(3'd4, r);
    checks++; if (r !== 32'h08) begin errors++; $display("FAIL wd_pend got=%h want=00000008", r); end
    wr(3'd4, 32'hFF); wr(3'd3, 32'hFF);
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
    checks++; if (bus.in_service !== 1'b0 || bus.irq_req !== 1'b0) begin errors++; $display("FAIL stray_ack insvc=%b req=%b want 0/0", bus.in_service, bus.irq_req); end
  endtask

  task automatic test_level();
    logic [31:0] r;
    wr(3'd1, 32'h0);
    wr(3'd5, 32'hFD);
    bus.irq_src = 8'h02;
    tick(); tick();
    wr(3'd4, 32'h02);
    rd(3'd4, r);
    checks++; if (r !== 32'h02) begin errors++; $display("FAIL lvl_hold got=%h want=00000002", r); end
    bus.irq_src = 8'h00;
    tick();
    wr(3'd4, 32'h02);
    rd(3'd4, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL lvl_clear got=%h want=0", r); end
    wr(3'd5, 32'hFF);
    bus.irq_src = 8'h40;
    wr(3'd4, 32'h40);
    bus.irq_src = 8'h00;
    rd(3'd4, r);
    checks++; if (r !== 32'h40) begin errors++; $display("FAIL set_wins got=%h want=00000040", r); end
    wr(3'd4, 32'h40);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rsvd7 got=%h want=0", r); end
    rd(3'd1, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL en_off got=%h want=0", r); end
    wr(3'd1, 32'h1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    exp_t e;
    expect_req(2);
    pulse(8'h04);
    wait_req(5);
    e = sb.pop_front();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_id !== e.id || bus.irq_vec !== e.vec) begin errors++; $display("FAIL rm_req req=%b id=%0d vec=%h want 1/%0d/%h", bus.irq_req, bus.irq_id, bus.irq_vec, e.id, e.vec); end
    ack();
    checks++; if (bus.in_service !== 1'b1) begin errors++; $display("FAIL rm_active got=%b want=1", bus.in_service); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.in_service !== 1'b0 || bus.irq_req !== 1'b0) begin errors++; $display("FAIL rm_outs insvc=%b req=%b want 0/0", bus.in_service, bus.irq_req); end
    checks++; if (bus.irq_vec !== 32'h0 || bus.irq_id !== 3'd0) begin errors++; $display("FAIL rm_vec vec=%h id=%0d want 0/0", bus.irq_vec, bus.irq_id); end
    rd(3'd1, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL rm_en got=%h want=0", r); end
    rd(3'd5, r);
    checks++; if (r !== 32'hFF) begin errors++; $display("FAIL rm_mode got=%h want=000000ff", r); end
    reset_n = 1'b1;
    tick();
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL sb_left got=%0d want=0", sb.size()); end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
    bus.irq_src = '0; bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_no_nesting();
    test_withdraw();
    test_level();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end
endmodule
